// File: rtl/ssm_sram_pkg.sv
// Shared types and helpers for the SRAM scan-out reader: address packing,
// scan state encoding and 4-bit-to-10-bit colour expansion.
package ssm_sram_pkg;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 16;
    localparam int COORD_W = 10;
    localparam int CH_W    = 10;
    localparam int PIX_W   = 12;  // colour bits actually kept from a word (d[15:4])

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } scan_state_e;

    // SRAM address layout is {x, y}
    function automatic logic [ADDR_W-1:0] pack_xy(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return {x, y};
    endfunction

    // d[15:4] -> {R, G, B}, each nibble placed in the top of a 10-bit channel
    function automatic logic [3*CH_W-1:0] rgb_expand(input logic [PIX_W-1:0] d);
        return {d[11:8], 6'b0, d[7:4], 6'b0, d[3:0], 6'b0};
    endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous prefetch FIFO. Flush beats push/pop; read data is registered
// on pop and holds otherwise.
module scanout_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_rdata;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_count = r_count;
    assign o_rdata = r_rdata;

    // storage write; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && w_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    // pointers, occupancy and registered read data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rdata  <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_scanout_reader.sv
// SRAM read port for VGA scan-out: prefetches the frame in raster order into
// a small FIFO, serves one pixel per display request, and time-shares the
// SRAM bus with a single-word write port for the drawing logic.
module sram_scanout_reader
    import ssm_sram_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFrame_Start,
    input  logic              iPix_Req,
    output logic [CH_W-1:0]   oRed,
    output logic [CH_W-1:0]   oGreen,
    output logic [CH_W-1:0]   oBlue,
    output logic              oUnderflow,
    input  logic              iWr_Req,
    input  logic [ADDR_W-1:0] iWr_Addr,
    input  logic [DATA_W-1:0] iWr_Data,
    output logic              oWr_Ack,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic              oSRAM_WE_N,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_DQ_OE,
    output logic [DATA_W-1:0] oSRAM_DQ,
    input  logic [DATA_W-1:0] iSRAM_DQ
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]      DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]    LWM_C   = CW'(LOW_WM);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    scan_state_e         r_state;
    logic [COORD_W-1:0]  r_x;
    logic [COORD_W-1:0]  r_y;
    logic                r_rd_inflight;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_dq;
    logic                r_oe_n;
    logic                r_we_n;
    logic                r_dq_oe;
    logic                r_wr_ack;
    logic                r_underflow;
    logic                r_zero;

    logic [PIX_W-1:0]    w_rdata;
    logic [CW-1:0]       w_count;
    logic                w_full;
    logic                w_empty;
    logic [CW:0]         w_level_sum;
    logic                w_wr_pend;
    logic                w_rd_elig;
    logic                w_do_rd;
    logic                w_do_wr;
    logic                w_push;
    logic                w_pop;
    logic                w_under;
    logic [3*CH_W-1:0]   w_rgb;
    logic                w_unused_lsb;

    // low nibble of each word carries no colour
    assign w_unused_lsb = ^iSRAM_DQ[3:0];

    // ack is registered, so the requester still shows the same request during
    // its ack cycle; masking it there prevents a duplicate write
    assign w_wr_pend   = iWr_Req && !r_wr_ack;
    assign w_level_sum = {1'b0, w_count} + {{CW{1'b0}}, r_rd_inflight};
    assign w_rd_elig   = (r_state == S_FETCH) && !iFrame_Start && !w_full &&
                         (w_level_sum < DEPTH_C);
    assign w_do_rd     = w_rd_elig && (!w_wr_pend || (w_count <= LWM_C));
    assign w_do_wr     = !w_do_rd && w_wr_pend;

    // read data lands at the end of its bus cycle; a restart discards it
    assign w_push  = r_rd_inflight && !iFrame_Start;
    assign w_pop   = iPix_Req && !w_empty && !iFrame_Start;
    assign w_under = iPix_Req && (w_empty || iFrame_Start);

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_flush (iFrame_Start),
        .i_push  (w_push),
        .i_wdata (iSRAM_DQ[15:4]),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // scan FSM: raster counters advance on every read issue
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else if (iFrame_Start) begin
            r_state <= S_FETCH;
            r_x     <= '0;
            r_y     <= '0;
        end else if (w_do_rd) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                if (r_y == Y_LAST)
                    r_state <= S_DONE;
                else
                    r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // registered SRAM bus: one read, one write or idle per cycle
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_addr        <= '0;
            r_dq          <= '0;
            r_oe_n        <= 1'b1;
            r_we_n        <= 1'b1;
            r_dq_oe       <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_rd_inflight <= 1'b0;
        end else begin
            r_oe_n        <= !w_do_rd;
            r_we_n        <= !w_do_wr;
            r_dq_oe       <= w_do_wr;
            r_wr_ack      <= w_do_wr;
            r_rd_inflight <= w_do_rd;
            if (w_do_rd)
                r_addr <= pack_xy(r_x, r_y);
            else if (w_do_wr) begin
                r_addr <= iWr_Addr;
                r_dq   <= iWr_Data;
            end
        end
    end

    // pixel status: zero the colour after a starved request, sticky underflow
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_underflow <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            if (w_under)
                r_underflow <= 1'b1;
            else if (iFrame_Start)
                r_underflow <= 1'b0;
            if (w_under)
                r_zero <= 1'b1;
            else if (w_pop)
                r_zero <= 1'b0;
        end
    end

    assign w_rgb  = r_zero ? '0 : rgb_expand(w_rdata);
    assign oRed   = w_rgb[3*CH_W-1 -: CH_W];
    assign oGreen = w_rgb[2*CH_W-1 -: CH_W];
    assign oBlue  = w_rgb[CH_W-1:0];

    assign oUnderflow  = r_underflow;
    assign oWr_Ack     = r_wr_ack;
    assign oSRAM_ADDR  = r_addr;
    assign oSRAM_DQ    = r_dq;
    assign oSRAM_OE_N  = r_oe_n;
    assign oSRAM_WE_N  = r_we_n;
    assign oSRAM_DQ_OE = r_dq_oe;

endmodule

// File: tb/tb_sram_scanout_reader.sv
// Randomized bench for sram_scanout_reader with a pixel/queue-level model.
module tb_sram_scanout_reader;
    localparam int H     = 640;
    localparam int V     = 3;
    localparam int DEPTH = 16;
    localparam int LWM   = 4;

    logic        clk = 1'b0;
    logic        rst, fs, pix, wr_req;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic [9:0]  red, green, blue;
    logic        under, ack, we_n, oe_n, dq_oe;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;

    // SRAM model: a read returns the low 16 address bits
    assign sram_dq_i = !oe_n ? sram_addr[15:0] : 16'hDEAD;

    always #5 clk = ~clk;

    sram_scanout_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH), .LOW_WM(LWM)) dut (
        .iCLK(clk), .iRST(rst), .iFrame_Start(fs), .iPix_Req(pix),
        .oRed(red), .oGreen(green), .oBlue(blue), .oUnderflow(under),
        .iWr_Req(wr_req), .iWr_Addr(wr_addr), .iWr_Data(wr_data), .oWr_Ack(ack),
        .oSRAM_ADDR(sram_addr), .oSRAM_WE_N(we_n), .oSRAM_OE_N(oe_n),
        .oSRAM_DQ_OE(dq_oe), .oSRAM_DQ(sram_dq_o), .iSRAM_DQ(sram_dq_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // expected outputs for the current cycle
    logic [19:0] e_addr;
    logic [15:0] e_dq;
    logic        e_oe_n, e_we_n, e_dq_oe, e_ack, e_under;
    logic [29:0] e_rgb;
    // model state: frame progress and FIFO occupancy in pixels
    bit m_fetch, m_inflight;
    int m_issued, m_level, m_popped;
    // write requester and counters
    bit wr_act, ack_seen;
    int n_rd, n_ack;

    function automatic int xy_addr(input int p);
        return (p % H) * 1024 + (p / H);
    endfunction

    function automatic logic [29:0] pix_rgb(input int p);
        int d;
        d = xy_addr(p) & 16'hFFFF;
        return 30'((((d >> 12) & 15) << 26) | (((d >> 8) & 15) << 16) | (((d >> 4) & 15) << 6));
    endfunction

    task automatic model_reset();
        e_addr = '0; e_dq = '0; e_oe_n = 1'b1; e_we_n = 1'b1; e_dq_oe = 1'b0;
        e_ack = 1'b0; e_under = 1'b0; e_rgb = '0;
        m_fetch = 0; m_inflight = 0; m_issued = 0; m_level = 0; m_popped = 0;
    endtask

    task automatic cycle(input bit do_rst, input bit do_fs, input int pix_pct, input int wr_pct);
        bit wr_pend, elig, do_rd, do_wr, pop_ok;
        @(posedge clk); #1;
        if (wr_act && ack_seen) wr_act = 0;
        if (!wr_act && int'($urandom_range(99)) < wr_pct) begin
            wr_act  = 1;
            wr_addr = 20'($urandom);
            wr_data = 16'($urandom);
        end
        wr_req = wr_act;
        rst    = do_rst;
        fs     = do_fs;
        pix    = int'($urandom_range(99)) < pix_pct;
        @(negedge clk);
        chk("addr",  32'(sram_addr), 32'(e_addr));
        chk("oe_n",  32'(oe_n),      32'(e_oe_n));
        chk("we_n",  32'(we_n),      32'(e_we_n));
        chk("dq_oe", 32'(dq_oe),     32'(e_dq_oe));
        chk("dq",    32'(sram_dq_o), 32'(e_dq));
        chk("ack",   32'(ack),       32'(e_ack));
        chk("rgb",   32'({red, green, blue}), 32'(e_rgb));
        chk("under", 32'(under),     32'(e_under));
        ack_seen = ack;
        if (!oe_n) n_rd++;
        if (ack) n_ack++;
        // next-cycle expectations from this cycle's inputs
        if (rst) begin
            model_reset();
        end else begin
            wr_pend = wr_req && !e_ack;
            elig    = m_fetch && !fs && (m_level + int'(m_inflight) < DEPTH);
            do_rd   = elig && (!wr_pend || m_level <= LWM);
            do_wr   = !do_rd && wr_pend;
            e_oe_n  = !do_rd;
            e_we_n  = !do_wr;
            e_dq_oe = do_wr;
            e_ack   = do_wr;
            if (do_rd) e_addr = 20'(xy_addr(m_issued));
            if (do_wr) begin e_addr = wr_addr; e_dq = wr_data; end
            pop_ok = pix && !fs && m_level > 0;
            if (pop_ok) begin e_rgb = pix_rgb(m_popped); m_popped++; end
            else if (pix) e_rgb = '0;
            if (pix && !pop_ok) e_under = 1'b1;
            else if (fs) e_under = 1'b0;
            if (fs) begin
                m_level = 0; m_popped = 0; m_fetch = 1; m_issued = 0;
            end else begin
                m_level = m_level + int'(m_inflight) - int'(pop_ok);
                if (do_rd) begin
                    m_issued++;
                    if (m_issued == H * V) m_fetch = 0;
                end
            end
            m_inflight = do_rd;
        end
    endtask

    initial begin
        rst = 1'b1; fs = 1'b0; pix = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        wr_act = 0; ack_seen = 0; n_rd = 0; n_ack = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr",  32'(sram_addr), 32'h0);
        chk("rst_oe_n",  32'(oe_n),      32'h1);
        chk("rst_we_n",  32'(we_n),      32'h1);
        chk("rst_dq_oe", 32'(dq_oe),     32'h0);
        chk("rst_ack",   32'(ack),       32'h0);
        chk("rst_rgb",   32'({red, green, blue}), 32'h0);
        chk("rst_under", 32'(under),     32'h0);
        cycle(1, 0, 0, 0);

        // prefetch fills exactly DEPTH entries then the bus idles
        n_rd = 0;
        cycle(0, 1, 0, 0);
        repeat (40) cycle(0, 0, 0, 0);
        chk("fill_reads", 32'(n_rd), 32'(DEPTH));

        // full-rate display across a line wrap
        repeat (700) cycle(0, 0, 100, 0);
        // mixed display and drawing traffic
        repeat (400) cycle(0, 0, 70, 40);
        // display stalled: FIFO full, writes take the bus
        n_ack = 0;
        repeat (60) cycle(0, 0, 0, 100);
        chk("full_writes", 32'(n_ack > 20), 32'h1);

        // request right after a restart starves
        cycle(0, 1, 0, 0);
        cycle(0, 0, 100, 0);
        cycle(0, 0, 0, 0);
        chk("under_set", 32'(under), 32'h1);
        chk("under_rgb", 32'({red, green, blue}), 32'h0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("under_clr", 32'(under), 32'h0);

        // mid-frame restart under load
        repeat (500) cycle(0, 0, 90, 20);
        cycle(0, 1, 50, 50);
        repeat (300) cycle(0, 0, 80, 30);

        // whole frame, then the fetch stops
        cycle(0, 1, 0, 0);
        repeat (2600) cycle(0, 0, 100, 30);
        n_rd = 0;
        repeat (50) cycle(0, 0, 100, 30);
        chk("done_no_reads", 32'(n_rd), 32'h0);

        // reset while writes are being served
        repeat (5) cycle(0, 0, 0, 100);
        repeat (3) cycle(1, 0, 0, 100);
        repeat (20) cycle(0, 0, 50, 50);
        cycle(0, 1, 50, 50);
        repeat (100) cycle(0, 0, 60, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_scanout_reader.md
# sram_scanout_reader

Read-side SRAM port for the VGA path: prefetches pixels from external SRAM in raster order into a small FIFO and delivers one 30-bit RGB pixel per display request. It owns the SRAM pins and arbitrates a single-word write port for the walker/drawing logic, so drawing and scan-out share the SRAM without tearing the address bus. Sits between the VGA timing controller and the SRAM pads, clocked by the VGA control clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- FIFO_DEPTH, 16, prefetch FIFO entries (power of two, ≥4)
- LOW_WM, 4, FIFO level at or below which reads beat writes

- iCLK  in  1  VGA control clock; all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- iFrame_Start  in  1  one-cycle pulse before the first active pixel of a frame
- iPix_Req  in  1  display consumes one pixel this cycle
- oRed, oGreen, oBlue  out  10 each  pixel colour, valid the cycle after iPix_Req
- oUnderflow  out  1  sticky: a request hit an empty FIFO
- iWr_Req  in  1  write request, held until acked
- iWr_Addr  in  20  write address {x[9:0], y[9:0]}
- iWr_Data  in  16  write data
- oWr_Ack  out  1  one-cycle pulse: write driven this cycle
- oSRAM_ADDR  out  20  SRAM address {x, y}
- oSRAM_WE_N, oSRAM_OE_N  out  1 each  SRAM strobes, active-low
- oSRAM_DQ_OE  out  1  pad driver enable for oSRAM_DQ
- oSRAM_DQ  out  16  write data to pads
- iSRAM_DQ  in  16  read data from pads

## Operation
- States: IDLE (no frame), FETCH (issuing reads), DONE (all H_ACTIVE×V_ACTIVE addresses issued).
- IDLE/DONE → FETCH on iFrame_Start: FIFO flushed, in-flight read discarded, fetch x=0, y=0, oUnderflow cleared. Applies mid-frame too (restart).
- FETCH: x increments 0..H_ACTIVE-1; at H_ACTIVE-1 x wraps to 0, y increments. Issuing address (H_ACTIVE-1, V_ACTIVE-1) → DONE.
- Read eligible when state=FETCH and fifo_count + inflight < FIFO_DEPTH.
- Arbitration per cycle: if read eligible and (!iWr_Req or fifo_count ≤ LOW_WM) → read; else if iWr_Req → write; else idle bus (OE_N=1, WE_N=1, address holds).
- Read cycle: oSRAM_ADDR={x,y}, OE_N=0, WE_N=1, DQ_OE=0; iSRAM_DQ captured next edge and pushed into FIFO.
- Write cycle: oSRAM_ADDR=iWr_Addr, oSRAM_DQ=iWr_Data, WE_N=0, OE_N=1, DQ_OE=1, oWr_Ack=1. Writes are allowed in every state.
- Pixel out: on iPix_Req with FIFO non-empty, pop; next cycle oRed={d[15:12],6'b0}, oGreen={d[11:8],6'b0}, oBlue={d[7:4],6'b0}. d[3:0] ignored.
- Underflow: iPix_Req with FIFO empty (push same cycle does not count) → next cycle RGB=0, oUnderflow=1; no pop.
- iPix_Req when no request: RGB holds last value.

## Timing
- Reset values: state IDLE, FIFO empty, inflight 0, x=y=0, oRed/oGreen/oBlue=0, oUnderflow=0, oWr_Ack=0, OE_N=1, WE_N=1, DQ_OE=0, oSRAM_ADDR=0, oSRAM_DQ=0.
- Read latency: address cycle N → FIFO entry visible cycle N+2 → RGB earliest N+3.
- SRAM outputs registered; inflight is 1 for the cycle after a read issue.
- Simultaneous push and pop: count unchanged, both succeed.
- Full FIFO: no read issued; writes get every cycle.
- iFrame_Start and iPix_Req same cycle: flush wins, pixel treated as underflow.
- iFrame_Start and iWr_Req same cycle: write still served.
- Reset mid-write: strobes deasserted next edge, no ack.
- Sustained throughput: one read per cycle; with display consuming each cycle, writes starve only while fifo_count ≤ LOW_WM.

## Structure
- Package ssm_sram_pkg: ADDR_W=20, DATA_W=16, pack_xy(x,y) address function, scan-state enum, RGB expansion function.
- Sub-module scanout_fifo: synchronous FIFO, DEPTH parameter, push/pop/flush, count, full/empty; read data registered.

## Test plan
- Reset then iFrame_Start, iPix_Req held off → 16 reads at {0,0}..{15,0}, then bus idle; FIFO full.
- SRAM model data=address[15:0]; request 640 pixels → RGB sequence matches x order, line wraps to {0,1} after {639,0}.
- iWr_Req held with FIFO level 10 → oWr_Ack next cycle, WE_N=0, DQ_OE=1, addr/data = iWr_Addr/iWr_Data.
- Level 3 with iWr_Req pending → read wins, ack withheld until level > 4 or FIFO full.
- iPix_Req immediately after iFrame_Start → RGB=0, oUnderflow=1; next iFrame_Start clears it.
- iFrame_Start at pixel {300,100} → FIFO flushed, next reads restart at {0,0}; after 307200 issues state=DONE, no further reads.
